// File: rtl/disp_queue.sv
// Dispatch queue: filters decode records by dispQue_id and buffers them in program
// order in a circular buffer, releasing up to OUTPORTS oldest entries per cycle.
package disp_queue_pkg;
  typedef struct packed {
    logic [1:0]  dispQue_id;
    logic [31:0] pc;
    logic [15:0] uop;
  } decInfo_t;
endpackage

module disp_queue
  import disp_queue_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int INPORTS  = 4,
  parameter int OUTPORTS = 2,
  parameter int QUE_ID   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_squash,
  input  logic     [INPORTS-1:0]            i_enq_vld,
  input  decInfo_t [INPORTS-1:0]            i_enq_inst,
  output logic                              o_can_enq,
  output logic     [OUTPORTS-1:0]           o_deq_vld,
  output decInfo_t [OUTPORTS-1:0]           o_deq_inst,
  input  logic     [OUTPORTS-1:0]           i_deq_req,
  output logic     [$clog2(DEPTH):0]        o_count
);

  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = IW + 1;
  localparam int PW1 = PW + 1;
  localparam logic [1:0] QID = 2'(QUE_ID);

  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic           can_enq_q, can_enq_d;
  decInfo_t       array_q [DEPTH];
  decInfo_t       array_d [DEPTH];

  logic [PW-1:0]      count;
  logic [PW-1:0]      count_d;
  logic [INPORTS-1:0] sel;
  logic               enq_fire;
  logic [PW-1:0]      enq_n;
  logic [PW-1:0]      deq_n;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  // Read side: valid window and data straight from the registered array.
  always_comb begin
    count      = wptr_q - rptr_q;
    o_deq_vld  = '0;
    o_deq_inst = '0;
    rd_ptr     = '0;
    for (int k = 0; k < OUTPORTS; k++) begin
      rd_ptr        = rptr_q + PW'(k);
      o_deq_vld[k]  = count > PW'(k);
      o_deq_inst[k] = array_q[rd_ptr[IW-1:0]];
    end
  end

  // Selected slots are packed densely from wptr upward; enq_n doubles as the running offset.
  always_comb begin
    sel      = '0;
    enq_fire = can_enq_q && !i_squash;
    array_d  = array_q;
    enq_n    = '0;
    wr_ptr   = '0;
    for (int i = 0; i < INPORTS; i++) begin
      sel[i] = i_enq_vld[i] && (i_enq_inst[i].dispQue_id == QID);
      if (enq_fire && sel[i]) begin
        wr_ptr                     = wptr_q + enq_n;
        array_d[wr_ptr[IW-1:0]]    = i_enq_inst[i];
        enq_n                      = enq_n + PW'(1);
      end
    end
  end

  always_comb begin
    deq_n = '0;
    for (int k = 0; k < OUTPORTS; k++) begin
      if (i_deq_req[k] && o_deq_vld[k]) begin
        deq_n = deq_n + PW'(1);
      end
    end
    if (i_squash) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      wptr_d = wptr_q + enq_n;
      rptr_d = rptr_q + deq_n;
    end
    count_d = wptr_d - rptr_d;
    // Space check ignores this cycle's sel and dequeue so it can be a plain flop.
    can_enq_d = ({1'b0, count_d} + PW1'(INPORTS)) <= PW1'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      can_enq_q <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      can_enq_q <= can_enq_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    array_q <= array_d;
  end

  assign o_can_enq = can_enq_q;
  assign o_count   = count;

endmodule

// File: tb/tb_disp_queue.sv
// Directed + random bench for disp_queue with a FIFO scoreboard of accepted records.
module tb_disp_queue;
  import disp_queue_pkg::*;

  localparam int DEPTH    = 16;
  localparam int INPORTS  = 4;
  localparam int OUTPORTS = 2;
  localparam int QUE_ID   = 0;

  logic                      clk;
  logic                      rst;
  logic                      i_squash;
  logic     [INPORTS-1:0]    i_enq_vld;
  decInfo_t [INPORTS-1:0]    i_enq_inst;
  logic                      o_can_enq;
  logic     [OUTPORTS-1:0]   o_deq_vld;
  decInfo_t [OUTPORTS-1:0]   o_deq_inst;
  logic     [OUTPORTS-1:0]   i_deq_req;
  logic     [4:0]            o_count;

  disp_queue #(.DEPTH(DEPTH), .INPORTS(INPORTS), .OUTPORTS(OUTPORTS), .QUE_ID(QUE_ID)) dut (
    .clk(clk), .rst(rst), .i_squash(i_squash), .i_enq_vld(i_enq_vld),
    .i_enq_inst(i_enq_inst), .o_can_enq(o_can_enq), .o_deq_vld(o_deq_vld),
    .o_deq_inst(o_deq_inst), .i_deq_req(i_deq_req), .o_count(o_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int       n_checks = 0;
  int       n_err    = 0;
  int       tag_cnt  = 0;
  logic     exp_can  = 1'b1;
  decInfo_t model[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_state();
    chk("count", 64'(o_count), 64'(model.size()));
    chk("can_enq", 64'(o_can_enq), 64'(exp_can));
    for (int k = 0; k < OUTPORTS; k++) begin
      chk("deq_vld", 64'(o_deq_vld[k]), 64'(model.size() > k));
      if (model.size() > k) chk("deq_peek", 64'(o_deq_inst[k]), 64'(model[k]));
    end
  endtask

  // One cycle: check outputs, drive inputs, update scoreboard, advance past the edge.
  task automatic step(input logic [3:0] vld, input logic [7:0] ids,
                      input logic [1:0] req, input logic sq);
    decInfo_t   ins [INPORTS];
    decInfo_t   exp_d;
    logic [1:0] req_p1;
    check_state();
    req_p1 = req + 2'd1;
    if ((req & req_p1) != 2'b00) begin
      $display("FAIL deq_req_prefix: observed %b required a prefix mask", req);
      $fatal(1, "non-prefix dequeue request");
    end
    for (int i = 0; i < INPORTS; i++) begin
      tag_cnt++;
      ins[i].dispQue_id = ids[2*i +: 2];
      ins[i].pc         = 32'h1000 + 32'(tag_cnt) * 32'd4;
      ins[i].uop        = 16'(tag_cnt);
      i_enq_inst[i]     = ins[i];
    end
    i_enq_vld = vld;
    i_deq_req = req;
    i_squash  = sq;
    if (sq) begin
      model.delete();
    end else begin
      for (int k = 0; k < OUTPORTS; k++) begin
        if (req[k] && model.size() > 0) begin
          exp_d = model.pop_front();
          chk("deq_data", 64'(o_deq_inst[k]), 64'(exp_d));
        end
      end
      if (exp_can) begin
        for (int i = 0; i < INPORTS; i++)
          if (vld[i] && ids[2*i +: 2] == 2'(QUE_ID)) model.push_back(ins[i]);
      end
    end
    exp_can = (DEPTH - model.size()) >= INPORTS;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_enq_vld = '0;
    i_deq_req = '0;
    i_squash  = 1'b0;
  endtask

  initial begin
    logic [3:0] rv;
    logic [7:0] rid;
    logic [1:0] rq;
    logic       rs;
    rst = 1'b0;
    i_enq_inst = '0;
    idle_inputs();
    #12;
    chk("reset_count", 64'(o_count), 64'd0);
    chk("reset_vld", 64'(o_deq_vld), 64'd0);
    chk("reset_can", 64'(o_can_enq), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // basic enqueue of a full matching group, then drain in order
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    chk("basic_count", 64'(o_count), 64'd4);
    chk("basic_vld", 64'(o_deq_vld), 64'b11);
    chk("basic_can", 64'(o_can_enq), 64'd1);
    step(4'b0000, 8'h00, 2'b11, 1'b0);
    step(4'b0000, 8'h00, 2'b11, 1'b0);

    // squash back to entry 0, then filter/compaction: ids {0,1,0,2}
    step(4'b0000, 8'h00, 2'b00, 1'b1);
    step(4'b1111, 8'b10_00_01_00, 2'b00, 1'b0);
    chk("filter_count", 64'(o_count), 64'd2);
    step(4'b0000, 8'h00, 2'b11, 1'b0);

    // full boundary at 13 entries
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b0001, 8'h00, 2'b00, 1'b0);
    chk("full_count", 64'(o_count), 64'd13);
    chk("full_can", 64'(o_can_enq), 64'd0);
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    chk("dropped_count", 64'(o_count), 64'd13);
    step(4'b0000, 8'h00, 2'b11, 1'b0);
    chk("after_deq_count", 64'(o_count), 64'd11);
    chk("after_deq_can", 64'(o_can_enq), 64'd1);
    for (int n = 0; n < 6; n++) step(4'b0000, 8'h00, 2'b11, 1'b0);

    // move both pointers to 14, then enqueue across the 15 -> 0 boundary
    step(4'b0000, 8'h00, 2'b00, 1'b1);
    for (int n = 0; n < 3; n++) step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b0011, 8'h00, 2'b00, 1'b0);
    for (int n = 0; n < 7; n++) step(4'b0000, 8'h00, 2'b11, 1'b0);
    chk("wrap_empty", 64'(o_count), 64'd0);
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    chk("wrap_count", 64'(o_count), 64'd4);
    step(4'b0000, 8'h00, 2'b11, 1'b0);
    step(4'b0000, 8'h00, 2'b11, 1'b0);

    // simultaneous enqueue of 3 and dequeue of 2 at count 5
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b0001, 8'h00, 2'b00, 1'b0);
    chk("sim_pre_count", 64'(o_count), 64'd5);
    step(4'b0111, 8'h00, 2'b11, 1'b0);
    chk("sim_count", 64'(o_count), 64'd6);
    for (int n = 0; n < 3; n++) step(4'b0000, 8'h00, 2'b11, 1'b0);

    // random traffic against the scoreboard
    for (int n = 0; n < 40; n++) begin
      rv = 4'($urandom_range(0, 15));
      for (int i = 0; i < INPORTS; i++)
        rid[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(1, 3));
      case ($urandom_range(0, 2))
        0:       rq = 2'b00;
        1:       rq = 2'b01;
        default: rq = 2'b11;
      endcase
      rs = ($urandom_range(0, 19) == 0);
      step(rv, rid, rq, rs);
    end

    // squash with enqueue and dequeue asserted
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b1111, 8'h00, 2'b11, 1'b1);
    chk("squash_count", 64'(o_count), 64'd0);
    chk("squash_vld", 64'(o_deq_vld), 64'd0);
    chk("squash_can", 64'(o_can_enq), 64'd1);

    // asynchronous reset in mid-cycle
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    step(4'b1111, 8'h00, 2'b00, 1'b0);
    check_state();
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 64'(o_count), 64'd0);
    chk("async_rst_vld", 64'(o_deq_vld), 64'd0);
    chk("async_rst_can", 64'(o_can_enq), 64'd1);
    rst = 1'b1;
    model.delete();
    exp_can = 1'b1;
    @(posedge clk);
    #1;
    step(4'b0101, 8'h00, 2'b00, 1'b0);
    step(4'b0000, 8'h00, 2'b11, 1'b0);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
